// File: rtl/qspi_flash_target_if.sv
// Backing-memory request port of the QSPI flash target.
//   mem_addr  : byte address presented with each strobe
//   mem_rd    : one-clk read strobe, mem_rdata valid on the following clk
//   mem_rdata : read byte returned by the memory
//   mem_wr    : one-clk write strobe qualifying mem_addr/mem_wdata
//   mem_wdata : write byte
// master = flash target side, slave = memory side.
interface qspi_flash_target_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_wr;
    logic [7:0]        mem_wdata;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/qspi_flash_target.sv
// QSPI flash-side responder: oversamples sclk/cs_n/io with clk, decodes
// opcode/address/dummy/data phases and serves reads/writes from a byte memory.
// Ports:
//   clk, resetn        : system clock, async active-low reset
//   sclk, cs_n, io_in  : QSPI link from the controller (mode 0)
//   io_out, io_oe      : driven io3..io0 and per-lane output enables
//   cfg_cmd_lanes      : opcode lane width (00/11 single, 01 dual, 10 quad)
//   mem                : backing-memory request port
//   cmd_valid/cmd_err  : one-clk pulses on opcode completion / unsupported opcode
//   cmd_opcode         : last completed opcode
//   wel                : write-enable latch
module qspi_flash_target #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DUMMY_CYC = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic [3:0]                 io_in,
    output logic [3:0]                 io_out,
    output logic [3:0]                 io_oe,
    input  logic [1:0]                 cfg_cmd_lanes,
    qspi_flash_target_if.master        mem,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_opcode,
    output logic                       cmd_err,
    output logic                       wel
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned SH_W  = 24;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RES   = 8'hAB;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_DREAD = 8'h3B;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_PP    = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DOUT, ST_DIN, ST_IGNORE
    } state_e;

    // Input synchronizers and edge-detect history
    logic [1:0] sclk_s_q, cs_s_q;
    logic [3:0] io_s1_q, io_s2_q;
    logic       sclk_prev_q, cs_prev_q;

    // cs sync resets low so a released reset with cs_n high shows no falling edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_s_q    <= '0;
            cs_s_q      <= '0;
            io_s1_q     <= '0;
            io_s2_q     <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_s_q    <= {sclk_s_q[0], sclk};
            cs_s_q      <= {cs_s_q[0], cs_n};
            io_s1_q     <= io_in;
            io_s2_q     <= io_s1_q;
            sclk_prev_q <= sclk_s_q[1];
            cs_prev_q   <= cs_s_q[1];
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_s_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s_q[1] & sclk_prev_q;
    assign cs_rise   = cs_s_q[1] & ~cs_prev_q;
    assign cs_fall   = ~cs_s_q[1] & cs_prev_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic [7:0]        out_sh_q, out_sh_d;
    logic [3:0]        io_out_q, io_out_d, io_oe_q, io_oe_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, rd_pend_q;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cmd_valid_q, cmd_valid_d, cmd_err_q, cmd_err_d;
    logic [7:0]        cmd_opcode_q, cmd_opcode_d;
    logic              wel_q, wel_d, op_done_q, op_done_d;

    // Shift-in candidates for each lane width
    logic [SH_W-1:0]  sh1, sh2, sh4, cmd_sh;
    logic [CNT_W-1:0] cmd_last, dout_last;
    logic [3:0]       dout_mask, dout_bits;
    logic [7:0]       dout_next, status;

    assign sh1    = {shreg_q[SH_W-2:0], io_s2_q[0]};
    assign sh2    = {shreg_q[SH_W-3:0], io_s2_q[1:0]};
    assign sh4    = {shreg_q[SH_W-5:0], io_s2_q};
    assign status = {6'b0, wel_q, 1'b0};

    // Opcode lane width and read-data lane layout
    always_comb begin
        cmd_sh   = sh1;
        cmd_last = CNT_W'(7);
        case (cfg_cmd_lanes)
            2'b01:   begin cmd_sh = sh2; cmd_last = CNT_W'(3); end
            2'b10:   begin cmd_sh = sh4; cmd_last = CNT_W'(1); end
            default: ;
        endcase
        dout_mask = 4'b0010;
        dout_bits = {2'b00, out_sh_q[7], 1'b0};
        dout_next = {out_sh_q[6:0], 1'b0};
        dout_last = CNT_W'(7);
        case (cmd_opcode_q)
            OP_DREAD: begin
                dout_mask = 4'b0011;
                dout_bits = {2'b00, out_sh_q[7:6]};
                dout_next = {out_sh_q[5:0], 2'b00};
                dout_last = CNT_W'(3);
            end
            OP_QREAD: begin
                dout_mask = 4'b1111;
                dout_bits = out_sh_q[7:4];
                dout_next = {out_sh_q[3:0], 4'b0000};
                dout_last = CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        out_sh_d     = out_sh_q;
        io_out_d     = io_out_q;
        io_oe_d      = io_oe_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        wel_d        = wel_q;
        op_done_d    = op_done_q;

        // Address advances the clk after a write has been presented
        if (mem_wr_q) mem_addr_d = mem_addr_q + ADDR_W'(1);
        if (rd_pend_q) out_sh_d = mem.mem_rdata;

        if (cs_s_q[1]) begin
            // Deselect wins over any sclk activity in the same cycle
            state_d   = ST_IDLE;
            io_oe_d   = 4'b0000;
            io_out_d  = 4'b0000;
            bit_cnt_d = '0;
            if (cs_rise && op_done_q) begin
                op_done_d = 1'b0;
                case (cmd_opcode_q)
                    OP_WREN:       wel_d = 1'b1;
                    OP_WRDI, OP_PP: wel_d = 1'b0;
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        op_done_d = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shreg_d   = cmd_sh;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == cmd_last) begin
                            bit_cnt_d    = '0;
                            cmd_valid_d  = 1'b1;
                            cmd_opcode_d = cmd_sh[7:0];
                            op_done_d    = 1'b1;
                            case (cmd_sh[7:0])
                                OP_WREN, OP_WRDI, OP_RES: state_d = ST_IGNORE;
                                OP_RDSR: begin
                                    state_d  = ST_DOUT;
                                    out_sh_d = status;
                                end
                                OP_READ, OP_DREAD, OP_QREAD, OP_PP: state_d = ST_ADDR;
                                default: begin
                                    state_d   = ST_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        shreg_d   = sh1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(23)) begin
                            bit_cnt_d  = '0;
                            mem_addr_d = ADDR_W'(sh1);
                            case (cmd_opcode_q)
                                OP_READ: begin
                                    state_d  = ST_DOUT;
                                    mem_rd_d = 1'b1;
                                end
                                OP_DREAD, OP_QREAD: begin
                                    state_d  = ST_DUMMY;
                                    mem_rd_d = 1'b1;
                                end
                                default: state_d = ST_DIN;
                            endcase
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DOUT;
                        end
                    end
                end
                ST_DOUT: begin
                    if (sclk_fall) begin
                        io_oe_d  = dout_mask;
                        io_out_d = dout_bits;
                        out_sh_d = dout_next;
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == dout_last) begin
                            bit_cnt_d = '0;
                            if (cmd_opcode_q == OP_RDSR) begin
                                out_sh_d = status;
                            end else begin
                                mem_addr_d = mem_addr_q + ADDR_W'(1);
                                mem_rd_d   = 1'b1;
                            end
                        end
                    end
                end
                ST_DIN: begin
                    if (sclk_rise) begin
                        shreg_d   = sh1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            if (wel_q) begin
                                mem_wr_d    = 1'b1;
                                mem_wdata_d = sh1[7:0];
                            end
                        end
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            out_sh_q     <= '0;
            io_out_q     <= '0;
            io_oe_q      <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            mem_wdata_q  <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            cmd_opcode_q <= '0;
            wel_q        <= 1'b0;
            op_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            out_sh_q     <= out_sh_d;
            io_out_q     <= io_out_d;
            io_oe_q      <= io_oe_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            rd_pend_q    <= mem_rd_q;
            mem_wdata_q  <= mem_wdata_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
            cmd_opcode_q <= cmd_opcode_d;
            wel_q        <= wel_d;
            op_done_q    <= op_done_d;
        end
    end

    assign io_out        = io_out_q;
    assign io_oe         = io_oe_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_opcode    = cmd_opcode_q;
    assign cmd_err       = cmd_err_q;
    assign wel           = wel_q;
endmodule

// File: tb/tb_qspi_flash_target.sv
// Bench for qspi_flash_target: acts as the QSPI controller, models the
// backing memory, and scoreboards read bytes and memory writes.
module tb_qspi_flash_target;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned HALF   = 5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sclk;
    logic        cs_n;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [1:0]  cfg_cmd_lanes;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic        cmd_err;
    logic        wel;

    qspi_flash_target_if #(.ADDR_W(ADDR_W)) mif ();

    qspi_flash_target #(.ADDR_W(ADDR_W), .DUMMY_CYC(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_oe         (io_oe),
        .cfg_cmd_lanes (cfg_cmd_lanes),
        .mem           (mif),
        .cmd_valid     (cmd_valid),
        .cmd_opcode    (cmd_opcode),
        .cmd_err       (cmd_err),
        .wel           (wel)
    );

    always #5 clk = ~clk;

    // Backing memory model: one-clk read latency
    logic [7:0] fmem [logic [23:0]];
    logic [7:0] rdata_r = 8'h00;
    always @(posedge clk) begin
        if (mif.mem_rd) rdata_r <= fmem.exists(mif.mem_addr) ? fmem[mif.mem_addr] : 8'hFF;
    end
    assign mif.mem_rdata = rdata_r;

    // Event logs filled from DUT outputs
    logic [7:0]  cmd_log [0:63];
    logic [23:0] rd_log  [0:255];
    logic [23:0] wr_alog [0:15];
    logic [7:0]  wr_dlog [0:15];
    int cmd_n = 0, rd_n = 0, wr_n = 0, err_n = 0, both_n = 0;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_log[cmd_n[5:0]] <= cmd_opcode;
            cmd_n <= cmd_n + 1;
        end
        if (mif.mem_rd) begin
            rd_log[rd_n[7:0]] <= mif.mem_addr;
            rd_n <= rd_n + 1;
        end
        if (mif.mem_wr) begin
            wr_alog[wr_n[3:0]] <= mif.mem_addr;
            wr_dlog[wr_n[3:0]] <= mif.mem_wdata;
            wr_n <= wr_n + 1;
        end
        if (cmd_err) err_n <= err_n + 1;
        if (mif.mem_rd && mif.mem_wr) both_n <= both_n + 1;
    end

    int total = 0;
    int bad   = 0;
    logic [3:0]  oe_acc;
    logic [7:0]  exp_q [$];
    logic [31:0] exp_wr_q [$];

    // One sclk period: present data, sample target output just before the rise
    task automatic xfer(input logic [3:0] d, output logic [3:0] q);
        io_in = d;
        repeat (HALF) @(negedge clk);
        q = io_out;
        oe_acc = oe_acc | io_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] lanes);
        logic [3:0] q;
        case (lanes)
            2'b01:   for (int i = 0; i < 4; i++) xfer({2'b00, b[7-2*i -: 2]}, q);
            2'b10:   for (int i = 0; i < 2; i++) xfer(b[7-4*i -: 4], q);
            default: for (int i = 0; i < 8; i++) xfer({3'b000, b[7-i]}, q);
        endcase
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic [3:0] q;
        for (int i = 0; i < 24; i++) xfer({3'b000, a[23-i]}, q);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        cs_begin();
        send_byte(op, 2'b00);
        cs_end();
    endtask

    // Reads nbytes single-lane bytes on io1 and scoreboards them
    task automatic read_single(input int nbytes, input string name);
        logic [3:0] q;
        logic [7:0] got, want;
        for (int b = 0; b < nbytes; b++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) begin
                xfer(4'h0, q);
                got = {got[6:0], q[1]};
            end
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s byte%0d: got %h want %h", name, b, got, want);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; cs_n = 1'b1; sclk = 1'b0; io_in = 4'h0; cfg_cmd_lanes = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({io_out, io_oe, mif.mem_addr, mif.mem_rd, mif.mem_wr, mif.mem_wdata,
             cmd_valid, cmd_opcode, cmd_err, wel} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero oe=%b addr=%h op=%h wel=%b", io_oe, mif.mem_addr, cmd_opcode, wel);
        end
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wren();
        int c0, e0;
        c0 = cmd_n; e0 = err_n; oe_acc = 4'h0;
        cfg_cmd_lanes = 2'b00;
        simple_cmd(8'h06);
        total++;
        if (cmd_n !== c0 + 1) begin bad++; $display("FAIL wren_valid_count: got %0d want %0d", cmd_n - c0, 1); end
        total++;
        if (cmd_log[c0[5:0]] !== 8'h06) begin bad++; $display("FAIL wren_opcode: got %h want 06", cmd_log[c0[5:0]]); end
        total++;
        if (wel !== 1'b1) begin bad++; $display("FAIL wren_wel: got %b want 1", wel); end
        total++;
        if (oe_acc !== 4'h0 || err_n !== e0) begin bad++; $display("FAIL wren_quiet: got oe=%b errs=%0d want oe=0000 errs=0", oe_acc, err_n - e0); end
    endtask

    task automatic test_dual_cmd();
        int c0, e0;
        c0 = cmd_n; e0 = err_n; oe_acc = 4'h0;
        cfg_cmd_lanes = 2'b01;
        cs_begin();
        send_byte(8'hAB, 2'b01);
        repeat (2) @(negedge clk);
        total++;
        if (cmd_n !== c0 + 1 || cmd_opcode !== 8'hAB) begin
            bad++; $display("FAIL dual_res_opcode: got n=%0d op=%h want n=1 op=ab", cmd_n - c0, cmd_opcode);
        end
        cs_end();
        total++;
        if (err_n !== e0) begin bad++; $display("FAIL dual_res_err: got %0d want 0", err_n - e0); end
        total++;
        if (oe_acc !== 4'h0) begin bad++; $display("FAIL dual_res_oe: got %b want 0000", oe_acc); end
        cfg_cmd_lanes = 2'b00;
    endtask

    task automatic test_read03();
        int r0;
        r0 = rd_n;
        fmem[24'h000010] = 8'hA5;
        fmem[24'h000011] = 8'h3C;
        cs_begin();
        send_byte(8'h03, 2'b00);
        send_addr(24'h000010);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        oe_acc = 4'h0;
        read_single(2, "read03");
        total++;
        if (oe_acc !== 4'b0010) begin bad++; $display("FAIL read03_oe: got %b want 0010", oe_acc); end
        cs_end();
        total++;
        if (rd_log[r0[7:0]] !== 24'h000010) begin bad++; $display("FAIL read03_addr0: got %h want 000010", rd_log[r0[7:0]]); end
        total++;
        if (rd_log[8'(r0 + 1)] !== 24'h000011) begin bad++; $display("FAIL read03_addr1: got %h want 000011", rd_log[8'(r0 + 1)]); end
    endtask

    task automatic test_quad_wrap();
        int r0;
        logic [3:0] q;
        logic [7:0] got, want;
        r0 = rd_n;
        fmem[24'hFFFFFF] = 8'h12;
        fmem[24'h000000] = 8'h34;
        cs_begin();
        send_byte(8'h6B, 2'b00);
        send_addr(24'hFFFFFF);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        for (int i = 0; i < 8; i++) xfer(4'h0, q);
        oe_acc = 4'h0;
        for (int b = 0; b < 2; b++) begin
            got = 8'h00;
            for (int i = 0; i < 2; i++) begin
                xfer(4'h0, q);
                got = {got[3:0], q};
            end
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL quad_byte%0d: got %h want %h", b, got, want); end
        end
        total++;
        if (oe_acc !== 4'b1111) begin bad++; $display("FAIL quad_oe: got %b want 1111", oe_acc); end
        cs_end();
        total++;
        if (rd_log[r0[7:0]] !== 24'hFFFFFF || rd_log[8'(r0 + 1)] !== 24'h000000) begin
            bad++; $display("FAIL quad_wrap_addr: got %h,%h want ffffff,000000", rd_log[r0[7:0]], rd_log[8'(r0 + 1)]);
        end
    endtask

    task automatic test_page_program();
        int w0;
        logic [31:0] want;
        simple_cmd(8'h04);
        total++;
        if (wel !== 1'b0) begin bad++; $display("FAIL wrdi_wel: got %b want 0", wel); end
        w0 = wr_n;
        cs_begin();
        send_byte(8'h02, 2'b00);
        send_addr(24'h000100);
        send_byte(8'h5A, 2'b00);
        cs_end();
        total++;
        if (wr_n !== w0) begin bad++; $display("FAIL pp_no_wel_write: got %0d writes want 0", wr_n - w0); end
        simple_cmd(8'h06);
        exp_wr_q.push_back({24'h000100, 8'h5A});
        cs_begin();
        send_byte(8'h02, 2'b00);
        send_addr(24'h000100);
        send_byte(8'h5A, 2'b00);
        cs_end();
        want = exp_wr_q.pop_front();
        total++;
        if (wr_n !== w0 + 1) begin
            bad++; $display("FAIL pp_write_count: got %0d want 1", wr_n - w0);
        end else if ({wr_alog[w0[3:0]], wr_dlog[w0[3:0]]} !== want) begin
            bad++; $display("FAIL pp_write_data: got %h want %h", {wr_alog[w0[3:0]], wr_dlog[w0[3:0]]}, want);
        end
        total++;
        if (wel !== 1'b0) begin bad++; $display("FAIL pp_wel_clear: got %b want 0", wel); end
    endtask

    task automatic test_bad_opcode();
        int e0;
        logic [3:0] q;
        e0 = err_n;
        cs_begin();
        send_byte(8'hFF, 2'b00);
        oe_acc = 4'h0;
        for (int i = 0; i < 16; i++) xfer(4'hF, q);
        cs_end();
        total++;
        if (err_n !== e0 + 1) begin bad++; $display("FAIL badop_err: got %0d want 1", err_n - e0); end
        total++;
        if (oe_acc !== 4'h0) begin bad++; $display("FAIL badop_oe: got %b want 0000", oe_acc); end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] q, nib;
        simple_cmd(8'h06);
        cs_begin();
        send_byte(8'h3B, 2'b00);
        send_addr(24'h000010);
        for (int i = 0; i < 8; i++) xfer(4'h0, q);
        nib = 4'h0;
        for (int i = 0; i < 2; i++) begin
            xfer(4'h0, q);
            nib = {nib[1:0], q[1:0]};
        end
        total++;
        if (nib !== 4'hA) begin bad++; $display("FAIL dread_nibble: got %h want a", nib); end
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if ({io_out, io_oe, mif.mem_addr, mif.mem_rd, mif.mem_wr, mif.mem_wdata,
             cmd_valid, cmd_opcode, cmd_err, wel} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got oe=%b addr=%h op=%h wel=%b", io_oe, mif.mem_addr, cmd_opcode, wel);
        end
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rdsr_after_reset();
        simple_cmd(8'h06);
        cs_begin();
        send_byte(8'h05, 2'b00);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        oe_acc = 4'h0;
        read_single(2, "rdsr");
        total++;
        if (oe_acc !== 4'b0010) begin bad++; $display("FAIL rdsr_oe: got %b want 0010", oe_acc); end
        cs_end();
        total++;
        if (both_n !== 0) begin bad++; $display("FAIL rd_wr_overlap: got %0d want 0", both_n); end
    endtask

    initial begin
        test_reset();
        test_wren();
        test_dual_cmd();
        test_read03();
        test_quad_wrap();
        test_page_program();
        test_bad_opcode();
        test_reset_mid_read();
        test_rdsr_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
